// File: rtl/rob_multi_wb_if.sv
// Bus bundle for rob_multi_wb: decoder alloc, writeback channels, commit,
// flush/redirect, operand queries and occupancy.
interface rob_multi_wb_if #(
  parameter int unsigned ROB_WIDTH_BIT = 4,
  parameter int unsigned WB_PORTS      = 2
);
  localparam int unsigned W = ROB_WIDTH_BIT;

  logic                    rdy_in;
  logic                    flush_in;
  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [1:0]              alloc_type;
  logic [4:0]              alloc_rd;
  logic                    alloc_done;
  logic [31:0]             alloc_value;
  logic [31:0]             alloc_pred_pc;
  logic [W-1:0]            alloc_tag;
  logic [WB_PORTS-1:0]     wb_valid;
  logic [WB_PORTS*W-1:0]   wb_tag;
  logic [WB_PORTS*32-1:0]  wb_value;
  logic                    commit_valid;
  logic                    commit_we;
  logic                    commit_store;
  logic [4:0]              commit_rd;
  logic [31:0]             commit_value;
  logic [W-1:0]            commit_tag;
  logic [W-1:0]            head_tag;
  logic                    flush_out;
  logic [31:0]             redirect_pc;
  logic [W-1:0]            q1_tag;
  logic [W-1:0]            q2_tag;
  logic                    q1_ready;
  logic                    q2_ready;
  logic [31:0]             q1_value;
  logic [31:0]             q2_value;
  logic [W:0]              count;
  logic                    full;
  logic                    empty;

  modport master (
    output rdy_in, flush_in, alloc_valid, alloc_type, alloc_rd, alloc_done,
           alloc_value, alloc_pred_pc, wb_valid, wb_tag, wb_value, q1_tag, q2_tag,
    input  alloc_ready, alloc_tag, commit_valid, commit_we, commit_store,
           commit_rd, commit_value, commit_tag, head_tag, flush_out, redirect_pc,
           q1_ready, q2_ready, q1_value, q2_value, count, full, empty
  );

  modport slave (
    input  rdy_in, flush_in, alloc_valid, alloc_type, alloc_rd, alloc_done,
           alloc_value, alloc_pred_pc, wb_valid, wb_tag, wb_value, q1_tag, q2_tag,
    output alloc_ready, alloc_tag, commit_valid, commit_we, commit_store,
           commit_rd, commit_value, commit_tag, head_tag, flush_out, redirect_pc,
           q1_ready, q2_ready, q1_value, q2_value, count, full, empty
  );
endinterface

// File: rtl/rob_multi_wb.sv
// Reorder buffer: in-order alloc, multi-port writeback, in-order single retire,
// mispredict resolution at commit, two operand queries.
// Optional: define ROB_BYPASS_EN to let queries see same-cycle writebacks.
module rob_multi_wb #(
  parameter int unsigned ROB_WIDTH_BIT = 4,
  parameter int unsigned WB_PORTS      = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  rob_multi_wb_if.slave bus
);
  localparam int unsigned W  = ROB_WIDTH_BIT;
  localparam int unsigned D  = 1 << W;
  localparam int unsigned CW = W + 1;

  typedef enum logic [1:0] {T_REG, T_STORE, T_BRANCH, T_NOP} rob_type_e;

  logic [D-1:0]  busy_q, busy_d, ready_q, ready_d;
  rob_type_e     type_q [D];
  rob_type_e     type_d [D];
  logic [4:0]    rd_q [D];
  logic [4:0]    rd_d [D];
  logic [31:0]   value_q [D];
  logic [31:0]   value_d [D];
  logic [31:0]   pred_q [D];
  logic [31:0]   pred_d [D];
  logic [W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          commit_valid_q, commit_valid_d, commit_we_q, commit_we_d;
  logic          commit_store_q, commit_store_d, flush_out_q, flush_out_d;
  logic [4:0]    commit_rd_q, commit_rd_d;
  logic [31:0]   commit_value_q, commit_value_d, redirect_pc_q, redirect_pc_d;
  logic [W-1:0]  commit_tag_q, commit_tag_d;
  logic          alloc_fire, commit_fire;
  logic [W-1:0]  wb_tag_a [WB_PORTS];
  logic [31:0]   wb_val_a [WB_PORTS];
  logic          q1_ready_c, q2_ready_c;
  logic [31:0]   q1_value_c, q2_value_c;

  // Unpack the writeback buses per port
  always_comb begin
    for (int unsigned i = 0; i < WB_PORTS; i++) begin
      wb_tag_a[i] = bus.wb_tag[i*W +: W];
      wb_val_a[i] = bus.wb_value[i*32 +: 32];
    end
  end

  // Next-state: flush, writeback, alloc, commit and mispredict recovery
  always_comb begin
    busy_d = busy_q;  ready_d = ready_q;  type_d = type_q;  rd_d = rd_q;
    value_d = value_q;  pred_d = pred_q;
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    commit_valid_d = 1'b0;  commit_we_d = 1'b0;  commit_store_d = 1'b0;
    flush_out_d = 1'b0;
    commit_rd_d = commit_rd_q;  commit_value_d = commit_value_q;
    commit_tag_d = commit_tag_q;  redirect_pc_d = redirect_pc_q;
    alloc_fire = 1'b0;  commit_fire = 1'b0;
    if (bus.rdy_in) begin
      if (bus.flush_in) begin
        busy_d = '0;  head_d = '0;  tail_d = '0;  count_d = '0;
      end else begin
        // ascending order so the higher port wins a shared tag
        for (int unsigned i = 0; i < WB_PORTS; i++) begin
          if (bus.wb_valid[i] && busy_q[wb_tag_a[i]]) begin
            ready_d[wb_tag_a[i]] = 1'b1;
            value_d[wb_tag_a[i]] = wb_val_a[i];
          end
        end
        alloc_fire  = bus.alloc_valid && !full_q;
        commit_fire = busy_q[head_q] && ready_q[head_q];
        if (alloc_fire) begin
          busy_d[tail_q]  = 1'b1;
          ready_d[tail_q] = bus.alloc_done;
          type_d[tail_q]  = rob_type_e'(bus.alloc_type);
          rd_d[tail_q]    = bus.alloc_rd;
          value_d[tail_q] = bus.alloc_value;
          pred_d[tail_q]  = bus.alloc_pred_pc;
          tail_d          = tail_q + W'(1);
        end
        count_d = count_q + CW'(alloc_fire) - CW'(commit_fire);
        if (commit_fire) begin
          busy_d[head_q] = 1'b0;
          head_d         = head_q + W'(1);
          commit_valid_d = 1'b1;
          commit_we_d    = (type_q[head_q] == T_REG) ||
                           (type_q[head_q] == T_BRANCH && rd_q[head_q] != 5'd0);
          commit_store_d = (type_q[head_q] == T_STORE);
          commit_rd_d    = rd_q[head_q];
          commit_value_d = value_q[head_q];
          commit_tag_d   = head_q;
          // mispredicted branch retires but squashes everything behind it
          if (type_q[head_q] == T_BRANCH && value_q[head_q] != pred_q[head_q]) begin
            flush_out_d   = 1'b1;
            redirect_pc_d = value_q[head_q];
            busy_d  = '0;  head_d = '0;  tail_d = '0;  count_d = '0;
          end
        end
      end
    end
    full_d  = (count_d == CW'(D));
    empty_d = (count_d == '0);
  end

  // Operand queries, optionally bypassing same-cycle writebacks
  always_comb begin
    q1_ready_c = busy_q[bus.q1_tag] && ready_q[bus.q1_tag];
    q1_value_c = value_q[bus.q1_tag];
    q2_ready_c = busy_q[bus.q2_tag] && ready_q[bus.q2_tag];
    q2_value_c = value_q[bus.q2_tag];
`ifdef ROB_BYPASS_EN
    for (int unsigned i = 0; i < WB_PORTS; i++) begin
      if (bus.wb_valid[i] && busy_q[wb_tag_a[i]]) begin
        if (wb_tag_a[i] == bus.q1_tag) begin
          q1_ready_c = 1'b1;
          q1_value_c = wb_val_a[i];
        end
        if (wb_tag_a[i] == bus.q2_tag) begin
          q2_ready_c = 1'b1;
          q2_value_c = wb_val_a[i];
        end
      end
    end
`endif
  end

  // State registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;  ready_q <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        type_q[i] <= T_REG;  rd_q[i] <= '0;  value_q[i] <= '0;  pred_q[i] <= '0;
      end
      head_q <= '0;  tail_q <= '0;  count_q <= '0;
      full_q <= 1'b0;  empty_q <= 1'b1;
      commit_valid_q <= 1'b0;  commit_we_q <= 1'b0;  commit_store_q <= 1'b0;
      commit_rd_q <= '0;  commit_value_q <= '0;  commit_tag_q <= '0;
      flush_out_q <= 1'b0;  redirect_pc_q <= '0;
    end else begin
      busy_q <= busy_d;  ready_q <= ready_d;  type_q <= type_d;  rd_q <= rd_d;
      value_q <= value_d;  pred_q <= pred_d;
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
      full_q <= full_d;  empty_q <= empty_d;
      commit_valid_q <= commit_valid_d;  commit_we_q <= commit_we_d;
      commit_store_q <= commit_store_d;  commit_rd_q <= commit_rd_d;
      commit_value_q <= commit_value_d;  commit_tag_q <= commit_tag_d;
      flush_out_q <= flush_out_d;  redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.alloc_ready  = !full_q;
  assign bus.alloc_tag    = tail_q;
  assign bus.head_tag     = head_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_we    = commit_we_q;
  assign bus.commit_store = commit_store_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_value = commit_value_q;
  assign bus.commit_tag   = commit_tag_q;
  assign bus.flush_out    = flush_out_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.q1_ready     = q1_ready_c;
  assign bus.q1_value     = q1_value_c;
  assign bus.q2_ready     = q2_ready_c;
  assign bus.q2_value     = q2_value_c;
endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed self-checking bench for rob_multi_wb (default parameters).
module tb_rob_multi_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  rob_multi_wb_if #(.ROB_WIDTH_BIT(4), .WB_PORTS(2)) bus ();

  rob_multi_wb #(.ROB_WIDTH_BIT(4), .WB_PORTS(2)) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_in      = 1'b0;
    bus.alloc_valid   = 1'b0;
    bus.alloc_type    = 2'd0;
    bus.alloc_rd      = 5'd0;
    bus.alloc_done    = 1'b0;
    bus.alloc_value   = 32'd0;
    bus.alloc_pred_pc = 32'd0;
    bus.wb_valid      = 2'b00;
    bus.wb_tag        = 8'd0;
    bus.wb_value      = 64'd0;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic done,
                       input logic [31:0] val, input logic [31:0] pc);
    bus.alloc_valid   = 1'b1;
    bus.alloc_type    = t;
    bus.alloc_rd      = rd;
    bus.alloc_done    = done;
    bus.alloc_value   = val;
    bus.alloc_pred_pc = pc;
    step();
    bus.alloc_valid   = 1'b0;
  endtask

  task automatic wb0(input logic [3:0] tag, input logic [31:0] val);
    bus.wb_valid = 2'b01;
    bus.wb_tag   = {4'd0, tag};
    bus.wb_value = {32'd0, val};
    step();
    bus.wb_valid = 2'b00;
  endtask

  task automatic do_flush();
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
  endtask

  initial begin
    bus.rdy_in = 1'b1;
    bus.q1_tag = 4'd0;
    bus.q2_tag = 4'd0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    check("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
    check("rst_head_tag", 32'(bus.head_tag), 32'd0);
    check("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("rst_flush_out", 32'(bus.flush_out), 32'd0);
    check("rst_redirect", bus.redirect_pc, 32'd0);

    // fill to full, then a refused 17th offer
    for (int i = 0; i < 16; i++) begin
      check("fill_tag", 32'(bus.alloc_tag), 32'(i));
      alloc(2'd0, 5'd1, 1'b0, 32'd0, 32'd0);
    end
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    alloc(2'd0, 5'd1, 1'b0, 32'd0, 32'd0);
    check("full_refuse_count", 32'(bus.count), 32'd16);
    check("full_refuse_tag", 32'(bus.alloc_tag), 32'd0);
    do_flush();
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_head", 32'(bus.head_tag), 32'd0);

    // out-of-order writeback, in-order commit
    alloc(2'd0, 5'd1, 1'b0, 32'd0, 32'd0);
    alloc(2'd0, 5'd2, 1'b0, 32'd0, 32'd0);
    alloc(2'd0, 5'd3, 1'b0, 32'd0, 32'd0);
    check("ooo_count", 32'(bus.count), 32'd3);
    wb0(4'd2, 32'd7);
    wb0(4'd1, 32'd5);
    check("ooo_no_commit", 32'(bus.commit_valid), 32'd0);
    wb0(4'd0, 32'd3);
    check("ooo_wait_commit", 32'(bus.commit_valid), 32'd0);
    step();
    check("ooo_c0_valid", 32'(bus.commit_valid), 32'd1);
    check("ooo_c0_tag", 32'(bus.commit_tag), 32'd0);
    check("ooo_c0_value", bus.commit_value, 32'd3);
    check("ooo_c0_we", 32'(bus.commit_we), 32'd1);
    check("ooo_c0_rd", 32'(bus.commit_rd), 32'd1);
    step();
    check("ooo_c1_tag", 32'(bus.commit_tag), 32'd1);
    check("ooo_c1_value", bus.commit_value, 32'd5);
    step();
    check("ooo_c2_tag", 32'(bus.commit_tag), 32'd2);
    check("ooo_c2_value", bus.commit_value, 32'd7);
    check("ooo_c2_valid", 32'(bus.commit_valid), 32'd1);
    step();
    check("ooo_pulse_end", 32'(bus.commit_valid), 32'd0);
    check("ooo_empty", 32'(bus.empty), 32'd1);

    // two ports writing the same tag: higher port wins
    alloc(2'd0, 5'd4, 1'b0, 32'd0, 32'd0);
    alloc(2'd0, 5'd5, 1'b0, 32'd0, 32'd0);
    bus.wb_valid = 2'b11;
    bus.wb_tag   = {4'd4, 4'd4};
    bus.wb_value = {32'h22, 32'h11};
    step();
    bus.wb_valid = 2'b00;
    bus.q1_tag = 4'd4;
    bus.q2_tag = 4'd3;
    #1;
    check("dual_q1_ready", 32'(bus.q1_ready), 32'd1);
    check("dual_q1_value", bus.q1_value, 32'h22);
    check("dual_q2_ready", 32'(bus.q2_ready), 32'd0);
    do_flush();

    // mispredicted branch at head with two younger entries
    alloc(2'd2, 5'd0, 1'b0, 32'd0, 32'h100);
    alloc(2'd0, 5'd6, 1'b0, 32'd0, 32'd0);
    alloc(2'd0, 5'd7, 1'b0, 32'd0, 32'd0);
    wb0(4'd0, 32'h104);
    step();
    check("mp_commit_valid", 32'(bus.commit_valid), 32'd1);
    check("mp_flush_out", 32'(bus.flush_out), 32'd1);
    check("mp_redirect", bus.redirect_pc, 32'h104);
    check("mp_commit_we", 32'(bus.commit_we), 32'd0);
    check("mp_commit_tag", 32'(bus.commit_tag), 32'd0);
    check("mp_count", 32'(bus.count), 32'd0);
    check("mp_empty", 32'(bus.empty), 32'd1);
    step();
    check("mp_flush_pulse", 32'(bus.flush_out), 32'd0);
    check("mp_commit_pulse", 32'(bus.commit_valid), 32'd0);

    // 40 back-to-back alloc/commit pairs wrap the tags
    for (int i = 0; i < 40; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_type  = 2'd0;
      bus.alloc_rd    = 5'd9;
      bus.alloc_done  = 1'b1;
      bus.alloc_value = 32'(i);
      step();
      check("wrap_count_le1", 32'(bus.count <= 5'd1), 32'd1);
      if (i > 0) begin
        check("wrap_commit_tag", 32'(bus.commit_tag), 32'((i - 1) % 16));
        check("wrap_commit_value", bus.commit_value, 32'(i - 1));
      end
    end
    idle();
    step();
    check("wrap_last_tag", 32'(bus.commit_tag), 32'd7);
    check("wrap_last_value", bus.commit_value, 32'd39);
    check("wrap_empty", 32'(bus.empty), 32'd1);

    // rdy_in low freezes alloc and commit
    bus.rdy_in = 1'b0;
    alloc(2'd0, 5'd2, 1'b1, 32'h55, 32'd0);
    check("frz_alloc_count", 32'(bus.count), 32'd0);
    check("frz_alloc_tag", 32'(bus.alloc_tag), 32'd8);
    bus.rdy_in = 1'b1;
    alloc(2'd0, 5'd2, 1'b1, 32'h55, 32'd0);
    check("frz_alloc_ok", 32'(bus.count), 32'd1);
    bus.rdy_in = 1'b0;
    step();
    check("frz_no_commit", 32'(bus.commit_valid), 32'd0);
    check("frz_hold_count", 32'(bus.count), 32'd1);
    bus.rdy_in = 1'b1;
    step();
    check("frz_commit", 32'(bus.commit_valid), 32'd1);
    check("frz_commit_value", bus.commit_value, 32'h55);
    check("frz_commit_tag", 32'(bus.commit_tag), 32'd8);

    // query in the same cycle as the writeback
    do_flush();
    for (int i = 0; i < 4; i++) alloc(2'd0, 5'(i + 1), 1'b0, 32'd0, 32'd0);
    bus.q1_tag   = 4'd3;
    bus.wb_valid = 2'b01;
    bus.wb_tag   = {4'd0, 4'd3};
    bus.wb_value = {32'd0, 32'hAB};
    #1;
`ifdef ROB_BYPASS_EN
    check("byp_q1_ready", 32'(bus.q1_ready), 32'd1);
    check("byp_q1_value", bus.q1_value, 32'hAB);
`else
    check("byp_q1_ready", 32'(bus.q1_ready), 32'd0);
`endif
    step();
    bus.wb_valid = 2'b00;
    #1;
    check("byp_after_ready", 32'(bus.q1_ready), 32'd1);
    check("byp_after_value", bus.q1_value, 32'hAB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rob_multi_wb.md
# rob_multi_wb

Parametrised reorder buffer for the out-of-order core: allocates entries in program order from the decoder, collects results from `WB_PORTS` independent writeback channels (RS ALU, LSB, ...), and retires one entry per cycle in order to the register file / LSB. It resolves branch mispredictions at commit, answers two operand-dependency queries per cycle, and exposes occupancy (`count`/`full`/`empty`) so the decoder can stall cleanly.

## Interface
Parameters:
- `ROB_WIDTH_BIT`, default 4: index width; depth `D = 2**ROB_WIDTH_BIT`.
- `WB_PORTS`, default 2: number of writeback channels.

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  asynchronous, active-high reset
- `rdy_in`  in  1  global ready; low freezes the block
- `flush_in`  in  1  external clear (synchronous, qualified by `rdy_in`)
- `alloc_valid`  in  1  decoder offers an instruction
- `alloc_ready`  out  1  `= !full`
- `alloc_type`  in  2  0 REG, 1 STORE, 2 BRANCH, 3 NOP
- `alloc_rd`  in  5  destination register
- `alloc_done`  in  1  result already known at issue
- `alloc_value`  in  32  result when `alloc_done`
- `alloc_pred_pc`  in  32  predicted next PC (BRANCH only)
- `alloc_tag`  out  `ROB_WIDTH_BIT`  tag given to the offered instruction (= tail)
- `wb_valid`  in  `WB_PORTS`  per-channel result strobe
- `wb_tag`  in  `WB_PORTS*ROB_WIDTH_BIT`  packed tags, port 0 in LSBs
- `wb_value`  in  `WB_PORTS*32`  packed results
- `commit_valid`  out  1  one-cycle retire pulse
- `commit_we`  out  1  retire writes `commit_rd`
- `commit_store`  out  1  retire is a STORE (LSB may perform it)
- `commit_rd`  out  5,  `commit_value`  out  32,  `commit_tag`  out  `ROB_WIDTH_BIT`
- `head_tag`  out  `ROB_WIDTH_BIT`  current head
- `flush_out`  out  1  one-cycle mispredict pulse
- `redirect_pc`  out  32  correct PC, valid with `flush_out`
- `q1_tag`, `q2_tag`  in  `ROB_WIDTH_BIT`;  `q1_ready`, `q2_ready`  out  1;  `q1_value`, `q2_value`  out  32
- `count`  out  `ROB_WIDTH_BIT+1`;  `full`  out  1;  `empty`  out  1

## Operation
- Per entry: `busy`, `ready`, `type`, `rd`, `value`, `pred_pc`. Pointers `head`/`tail` wrap naturally mod D; `count` in the range 0..D; `full = (count == D)`; `empty = (count == 0)`.
- Alloc fires when `alloc_valid && alloc_ready && rdy_in`. The entry at `tail` is written with `busy=1`, `ready=alloc_done`, and `tail`/`count` increment.
- Writeback: for each port with `wb_valid[i]` and `busy[tag]`, set `ready=1` and `value=wb_value[i]`. Writebacks to non-busy entries are ignored. If two ports hit the same tag, the higher port index wins.
- Commit fires when `busy[head] && ready[head] && rdy_in`. The entry is freed, `head` increments, and the registered outputs are loaded: `commit_valid=1`, `commit_we = (type==REG) || (type==BRANCH && rd!=0)`, `commit_store = (type==STORE)`, plus rd/value/tag.
- Branch at commit: if `value != pred_pc`, the block drives `flush_out=1` and `redirect_pc=value`. At the same edge it clears all entries: `head=tail=count=0`. The branch itself still retires (`commit_valid=1`). Allocs in that cycle are discarded.
- `flush_in` (with `rdy_in`): clears all entries, pointers and count. It drops any same-cycle alloc, writeback or commit. Pulse registers clear.
- Simultaneous alloc and commit: `count` is unchanged. An alloc is refused when `full`, even if a commit occurs in the same cycle.
- Query: `qN_ready = busy[qN_tag] && ready[qN_tag]`; `qN_value = value[qN_tag]`. Both are combinational.
- `rdy_in` low: all state holds; `commit_valid` and `flush_out` clear to 0.

## Timing
- Reset (async): `commit_*`, `flush_out`, `redirect_pc`, `count`, `full`, `head_tag`, `alloc_tag` = 0; `empty=1`, `alloc_ready=1`; all entries idle.
- Writeback at edge N makes the entry committable at edge N+1; `commit_valid` is visible during cycle N+1.
- An alloc with `alloc_done=1` at edge N commits at edge N+1 at the earliest, if it is at the head.
- `flush_out` and `commit_valid` are single-cycle pulses.

## Configuration
- `ROB_BYPASS_EN` defined: a query also matches the same-cycle `wb_valid`/`wb_tag` on a busy entry. In that case it returns `ready=1` with that port's value, and the highest matching port wins.
- `ROB_BYPASS_EN` undefined: queries see registered entry state only, so the result becomes visible one cycle after writeback.

## Test plan
- Fill: 16 allocs with `alloc_done=0` (default params) → `full=1`, `alloc_ready=0`, `count=16`; the 17th offer is not accepted and `alloc_tag` stays 0.
- Out-of-order writeback: alloc tags 0,1,2; write back tag 2 (value 7), then tag 1 (value 5), then tag 0 (value 3) → commits occur in order 0,1,2 with values 3,5,7, one per cycle.
- Dual-port same tag: `wb_valid=2'b11`, both ports tag 4, values 0x11 and 0x22 → the entry holds 0x22.
- Mispredict: BRANCH with `pred_pc=0x100`, written back with 0x104, two younger entries behind it → `commit_valid` and `flush_out` pulse together, `redirect_pc=0x104`, then `count=0` and `empty=1`.
- Wrap: run 40 alloc/commit pairs → tags wrap 15→0 and `count` is never more than 1.
- Bypass: query tag 3 in the same cycle as its writeback of 0xAB → `q1_ready=1` and `q1_value=0xAB` with `ROB_BYPASS_EN` defined, `q1_ready=0` without it.
